// File: rtl/digits_uart_tx.sv
// Serialises a BCD digit stream as one ASCII text line (leading zeros suppressed, CR LF
// appended) onto an 8N1 UART line, buffered through a small character FIFO.
`timescale 1ns/1ps

module digits_uart_tx #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit,
  input  logic       leading_zero,
  input  logic       sending,
  output logic       txd,
  output logic       busy,
  output logic       overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1'b1);
  localparam logic [BW-1:0] BAUD_ZERO = BW'(1'b0);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1'b1);
  localparam logic [AW:0]   PTR_ZERO  = (AW + 1)'(1'b0);

  typedef enum logic [2:0] {
    F_IDLE,
    F_DIGITS,
    F_CR,
    F_LF,
    F_REJECT
  } frame_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic logic [7:0] ascii_of(input logic [3:0] d);
    return {4'h0, d} + 8'h30;
  endfunction

  frame_state_t frame_state_r;
  logic         seen_nz_r;
  logic         busy_r;
  logic         overrun_r;
  logic         push_s;
  logic [7:0]   push_data_s;
  logic         accept_s;
  logic         reject_s;

  logic [7:0]   mem_r [FIFO_DEPTH];
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic         full_s;
  logic         empty_s;
  logic         wr_en_s;
  logic         drop_s;
  logic         pop_s;
  logic [7:0]   rd_data_s;

  tx_state_t    tx_state_r;
  logic [BW-1:0] baud_r;
  logic [2:0]   bit_idx_r;
  logic [7:0]   shift_r;
  logic         txd_r;
  logic         baud_done_s;
  logic         quiet_s;

  // Decide what the frame logic pushes this cycle and whether a new frame is taken or refused.
  always_comb begin
    push_s      = 1'b0;
    push_data_s = 8'h00;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
    case (frame_state_r)
      F_IDLE: begin
        if (sending) begin
          if (busy_r) begin
            reject_s = 1'b1;
          end else begin
            accept_s    = 1'b1;
            push_s      = !leading_zero;
            push_data_s = ascii_of(digit);
          end
        end else begin
          push_s = 1'b0;
        end
      end
      F_DIGITS: begin
        if (sending) begin
          push_s      = !leading_zero;
          push_data_s = ascii_of(digit);
        end else begin
          push_s      = !seen_nz_r;
          push_data_s = 8'h30;
        end
      end
      F_CR: begin
        push_s      = 1'b1;
        push_data_s = 8'h0D;
      end
      F_LF: begin
        push_s      = 1'b1;
        push_data_s = 8'h0A;
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Frame tracking: digits, optional lone '0', then CR and LF on consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_state_r <= F_IDLE;
      seen_nz_r     <= 1'b0;
    end else begin
      case (frame_state_r)
        F_IDLE: begin
          if (accept_s) begin
            frame_state_r <= F_DIGITS;
            seen_nz_r     <= !leading_zero;
          end else if (reject_s) begin
            frame_state_r <= F_REJECT;
          end else begin
            frame_state_r <= F_IDLE;
          end
        end
        F_DIGITS: begin
          if (sending) begin
            if (!leading_zero) begin
              seen_nz_r <= 1'b1;
            end
          end else begin
            frame_state_r <= F_CR;
          end
        end
        F_CR: begin
          frame_state_r <= F_LF;
        end
        F_LF: begin
          frame_state_r <= F_IDLE;
          seen_nz_r     <= 1'b0;
        end
        F_REJECT: begin
          if (!sending) begin
            frame_state_r <= F_IDLE;
          end
        end
        default: begin
          frame_state_r <= F_IDLE;
          seen_nz_r     <= 1'b0;
        end
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still kept then.
  assign full_s      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s     = (wr_ptr_r == rd_ptr_r);
  assign wr_en_s     = push_s && (!full_s || pop_s);
  assign drop_s      = push_s && full_s && !pop_s;
  assign rd_data_s   = mem_r[rd_ptr_r[AW-1:0]];
  assign baud_done_s = (baud_r == BAUD_LAST);
  assign pop_s       = !empty_s && ((tx_state_r == TX_IDLE) ||
                                    ((tx_state_r == TX_STOP) && baud_done_s));

  // Character storage.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // UART transmitter; txd is registered so it lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_r <= TX_IDLE;
      baud_r     <= BAUD_ZERO;
      bit_idx_r  <= 3'd0;
      shift_r    <= 8'h00;
      txd_r      <= 1'b1;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          baud_r    <= BAUD_ZERO;
          bit_idx_r <= 3'd0;
          if (pop_s) begin
            shift_r    <= rd_data_s;
            tx_state_r <= TX_START;
            txd_r      <= 1'b0;
          end else begin
            txd_r <= 1'b1;
          end
        end
        TX_START: begin
          if (baud_done_s) begin
            baud_r     <= BAUD_ZERO;
            bit_idx_r  <= 3'd0;
            tx_state_r <= TX_DATA;
            txd_r      <= shift_r[0];
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        TX_DATA: begin
          if (baud_done_s) begin
            baud_r <= BAUD_ZERO;
            if (bit_idx_r == 3'd7) begin
              tx_state_r <= TX_STOP;
              txd_r      <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              txd_r     <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        TX_STOP: begin
          if (baud_done_s) begin
            baud_r <= BAUD_ZERO;
            if (pop_s) begin
              shift_r    <= rd_data_s;
              tx_state_r <= TX_START;
              txd_r      <= 1'b0;
            end else begin
              tx_state_r <= TX_IDLE;
              txd_r      <= 1'b1;
            end
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          baud_r     <= BAUD_ZERO;
          bit_idx_r  <= 3'd0;
          txd_r      <= 1'b1;
        end
      endcase
    end
  end

  assign quiet_s = (tx_state_r == TX_IDLE) && empty_s && (frame_state_r == F_IDLE);

  // Status flags: busy spans the whole line, overrun flags any dropped digit or frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      busy_r    <= accept_s || (busy_r && !quiet_s);
      overrun_r <= reject_s || drop_s;
    end
  end

  assign txd     = txd_r;
  assign busy    = busy_r;
  assign overrun = overrun_r;

endmodule

// File: tb/tb_digits_uart_tx.sv
// Directed bench for digits_uart_tx: scoreboarded UART decode of each transmitted line.
`timescale 1ns/1ps

module tb_digits_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] digit = 4'h0;
  logic       leading_zero = 1'b0;
  logic       sending = 1'b0;
  logic       txd;
  logic       busy;
  logic       overrun;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  bit   mon_busy = 1'b0;
  int   mon_cnt = 0;
  int   first_start = -1;
  int   last_start = -1;
  logic [9:0] mon_bits;
  int   ovr_cycles = 0;
  int   ovr_pulses = 0;
  logic ovr_prev = 1'b0;

  digits_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .digit(digit),
    .leading_zero(leading_zero),
    .sending(sending),
    .txd(txd),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // UART receiver: sample each bit mid-way, compare each char against the scoreboard.
  initial begin
    logic [8:0] exp9;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_busy = 1'b0;
        mon_cnt  = 0;
      end else if (!mon_busy) begin
        if (txd === 1'b0) begin
          mon_busy = 1'b1;
          mon_cnt  = 0;
          if (first_start < 0) first_start = cyc;
          last_start = cyc;
        end
      end else begin
        mon_cnt++;
        if (mon_cnt % CPB == CPB / 2) mon_bits[mon_cnt / CPB] = txd;
        if (mon_cnt == 9 * CPB + CPB / 2) begin
          mon_busy = 1'b0;
          exp9 = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h1FF;
          check("uart_char", {23'd0, 1'b0, mon_bits[8:1]}, {23'd0, exp9});
          check("uart_framing", {30'd0, mon_bits[9], mon_bits[0]}, 32'd2);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (overrun === 1'b1) ovr_cycles++;
      if (overrun === 1'b1 && ovr_prev !== 1'b1) ovr_pulses++;
      ovr_prev = overrun;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic send_frame(input logic [19:0] digs, input logic [4:0] lzs, input bit model);
    bit any_nz = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      sending      = 1'b1;
      digit        = digs[19 - 4 * i -: 4];
      leading_zero = lzs[4 - i];
      if (model && !lzs[4 - i]) begin
        exp_q.push_back(8'h30 + {4'h0, digs[19 - 4 * i -: 4]});
        any_nz = 1'b1;
      end
    end
    @(posedge clk); #1;
    sending      = 1'b0;
    digit        = 4'h0;
    leading_zero = 1'b0;
    if (model) begin
      if (!any_nz) exp_q.push_back(8'h30);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic wait_idle(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && !mon_busy && exp_q.size() == 0) done = 1'b1;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int bad;
    bit hit;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);

    // Idle line after reset.
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("idle_100_cycles", bad, 0);
    check("idle_no_chars", first_start, -1);

    // 123 with two suppressed leading zeros.
    send_frame(20'h00123, 5'b11000, 1'b1);
    @(negedge clk);
    check("busy_during_line", {31'd0, busy}, 32'd1);
    wait_idle("done_123");
    check("no_overrun_123", ovr_pulses, 0);

    // Widest line, back-to-back chars.
    first_start = -1;
    send_frame(20'h65535, 5'b00000, 1'b1);
    wait_idle("done_65535");
    check("span_70_bits", last_start - first_start + 10 * CPB, 70 * CPB);

    // Value zero collapses to a single '0'.
    send_frame(20'h00000, 5'b11111, 1'b1);
    wait_idle("done_zero");
    check("no_overrun_before_t4", ovr_pulses, 0);

    // A frame arriving while busy is refused whole.
    send_frame(20'h00045, 5'b11100, 1'b1);
    repeat (6) @(posedge clk);
    send_frame(20'h00999, 5'b11100, 1'b0);
    wait_idle("done_overrun_line");
    check("overrun_pulses", ovr_pulses, 1);
    check("overrun_width", ovr_cycles, 1);

    // Reset in DATA bit 3 of the first char, then a clean line.
    send_frame(20'h00077, 5'b11100, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (mon_busy && mon_cnt == 4 * CPB + 1) hit = 1'b1;
    end
    check("reached_data_bit3", {31'd0, hit}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_txd", {31'd0, txd}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    send_frame(20'h00012, 5'b11100, 1'b1);
    wait_idle("done_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
